// File: rtl/switch_game_engine_if.sv
// Switch game engine bus: game control/switch inputs and the score, timer and prompt outputs.
// The board-side logic drives through the master modport; the engine uses the slave modport.
interface switch_game_engine_if #(
   parameter int NUM_SW  = 10,
   parameter int TIME_W  = 5,
   parameter int SCORE_W = 12
);
   logic                start;
   logic [NUM_SW-1:0]   sw;
   logic [NUM_SW-1:0]   prompt_led;
   logic [TIME_W-1:0]   time_left;
   logic [SCORE_W-1:0]  score;
   logic [7:0]          rounds;
   logic                playing;
   logic                game_over;

   modport master (
      output start, sw,
      input  prompt_led, time_left, score, rounds, playing, game_over
   );

   modport slave (
      input  start, sw,
      output prompt_led, time_left, score, rounds, playing, game_over
   );
endinterface

// File: rtl/switch_game_engine.sv
// Round engine for the switch game: countdown timer, LFSR-chosen one-hot prompts,
// judgement of every switch change, and a saturating score whose points-per-round
// double every BONUS_PERIOD rounds.
// Optional feature: define SWITCH_DEBOUNCE_EN to put a per-switch counter filter
// (DEBOUNCE_CYC stable cycles) in front of the switch synchroniser.
module switch_game_engine #(
   parameter int          NUM_SW       = 10,
   parameter int          CLK_HZ       = 50_000_000,
   parameter int          GAME_SECONDS = 20,
   parameter int          SCORE_W      = 12,
   parameter int          BONUS_PERIOD = 5,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
`ifdef SWITCH_DEBOUNCE_EN
   ,
   parameter int          DEBOUNCE_CYC = 500_000
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   switch_game_engine_if.slave   bus
);

   localparam int TIME_W = $clog2(GAME_SECONDS + 1);
   localparam int IDX_W  = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
   localparam int CNT_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   typedef enum logic [2:0] {IDLE, PICK, WAIT, SCORE, OVER} state_t;

   state_t              state;
   logic [15:0]         lfsr;
   logic [NUM_SW-1:0]   sw_filt;
   logic [NUM_SW-1:0]   sw_q;
   logic [NUM_SW-1:0]   sw_p;
   logic [NUM_SW-1:0]   expected_r;
   logic [NUM_SW-1:0]   prompt_r;
   logic [IDX_W-1:0]    prev_idx;
   logic                prev_valid;
   logic [IDX_W-1:0]    raw_idx;
   logic [IDX_W-1:0]    pick_idx;
   logic [CNT_W-1:0]    tick_cnt;
   logic [TIME_W-1:0]   time_left_r;
   logic [SCORE_W-1:0]  score_r;
   logic [SCORE_W:0]    score_sum;
   logic [7:0]          rounds_r;
   logic                playing_r;
   logic                game_over_r;
   logic [2:0]          shift_amt;
   logic [8:0]          points;
   int                  rounds_div;
   logic                tick;
   logic                timeout;
   logic                change;

`ifdef SWITCH_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

   logic [DB_W-1:0] db_cnt [NUM_SW];

   // Each switch bit only adopts a new level after DEBOUNCE_CYC consecutive cycles at that level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_filt <= '0;
         for (int i = 0; i < NUM_SW; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SW; i++) begin
            if (bus.sw[i] != sw_filt[i]) begin
               if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                  sw_filt[i] <= bus.sw[i];
                  db_cnt[i]  <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end
`else
   assign sw_filt = bus.sw;
`endif

   // Free-running Galois LFSR; advancing every cycle turns player timing into prompt entropy.
   always_ff @(posedge clk) begin
      if (reset) lfsr <= LFSR_SEED;
      else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // One-stage switch sampler plus the previous sample; sw_p holds still through PICK/SCORE so
   // changes made there are still seen as a change once WAIT is entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_q <= '0;
         sw_p <= '0;
      end else begin
         sw_q <= sw_filt;
         if (bus.start || !(state == PICK || state == SCORE)) sw_p <= sw_q;
      end
   end

   // Prompt index: LFSR byte folded onto the switch range, bumped by one if it repeats the last prompt.
   always_comb begin
      raw_idx  = IDX_W'(lfsr[7:0] % 8'(NUM_SW));
      pick_idx = raw_idx;
      if (prev_valid && (raw_idx == prev_idx))
         pick_idx = (raw_idx == IDX_W'(NUM_SW - 1)) ? '0 : raw_idx + 1'b1;
   end

   // Points for this round (2, 4, 8 ... 256) and the saturating score sum.
   always_comb begin
      rounds_div = int'(rounds_r) / BONUS_PERIOD;
      shift_amt  = (rounds_div > 7) ? 3'd7 : 3'(rounds_div);
      points     = 9'd2 << shift_amt;
      score_sum  = {1'b0, score_r} + (SCORE_W + 1)'(points);
   end

   assign change  = (sw_q != sw_p);
   assign tick    = playing_r && (tick_cnt == CNT_W'(CLK_HZ - 1));
   assign timeout = tick && (time_left_r == TIME_W'(1));

   // Game FSM with timer; start beats timeout, and timeout beats any switch judgement on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         prompt_r    <= '0;
         expected_r  <= '0;
         prev_idx    <= '0;
         prev_valid  <= 1'b0;
         tick_cnt    <= '0;
         time_left_r <= '0;
         score_r     <= '0;
         rounds_r    <= '0;
         playing_r   <= 1'b0;
         game_over_r <= 1'b0;
      end else if (bus.start) begin
         state       <= PICK;
         prompt_r    <= '0;
         prev_valid  <= 1'b0;
         tick_cnt    <= '0;
         time_left_r <= TIME_W'(GAME_SECONDS);
         score_r     <= '0;
         rounds_r    <= '0;
         playing_r   <= 1'b1;
         game_over_r <= 1'b0;
      end else begin
         if (playing_r) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick)      time_left_r <= time_left_r - 1'b1;
         if (timeout) begin
            state       <= OVER;
            prompt_r    <= '1;
            playing_r   <= 1'b0;
            game_over_r <= 1'b1;
         end else begin
            case (state)
               IDLE: ;
               PICK: begin
                  prompt_r   <= NUM_SW'(1) << pick_idx;
                  expected_r <= sw_q ^ (NUM_SW'(1) << pick_idx);
                  prev_idx   <= pick_idx;
                  prev_valid <= 1'b1;
                  state      <= WAIT;
               end
               WAIT: begin
                  if (change) begin
                     if (sw_q == expected_r) begin
                        state <= SCORE;
                     end else begin
                        state       <= OVER;
                        prompt_r    <= '1;
                        playing_r   <= 1'b0;
                        game_over_r <= 1'b1;
                     end
                  end
               end
               SCORE: begin
                  score_r  <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                  rounds_r <= (rounds_r == 8'hFF) ? rounds_r : rounds_r + 1'b1;
                  state    <= PICK;
               end
               OVER: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.prompt_led = prompt_r;
   assign bus.time_left  = time_left_r;
   assign bus.score      = score_r;
   assign bus.rounds     = rounds_r;
   assign bus.playing    = playing_r;
   assign bus.game_over  = game_over_r;

endmodule
